// File: rtl/pooling_controller.sv
// pooling_controller
//   Control FSM for a 2x2 / stride-2 max-pooling unit. Counts a raster pixel
//   stream and produces registered (latency 1) control for the pooling
//   pipeline register stage that follows it.
//
//   Optional feature: define POOL_ABORT_EN to add the abort input.
//
// Ports
//   clk        in   rising-edge clock
//   nrst       in   asynchronous active-low reset
//   start      in   begin a frame (honoured only in IDLE)
//   pix_valid  in   one input pixel this cycle (accepted only in RUN)
//   abort      in   [POOL_ABORT_EN] cancel the current frame
//   busy       out  high in RUN and DONE
//   ctl_valid  out  control outputs valid this cycle (stage enable)
//   adrs       out  line-buffer address = col>>1
//   adrs_out   out  output-map write address
//   mux_en     out  second pixel of a horizontal pair
//   wr_ctrl1   out  even row, odd col: write pair max to line buffer
//   wr_ctrl2   out  odd row, odd col: compare with line buffer, write output
//   pool_done  out  pulse with the final wr_ctrl2 of a frame
module pooling_controller #(
   parameter int address_num = 4,
   parameter int IMG_W       = 8,
   parameter int IMG_H       = 8
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   start,
   input  logic                   pix_valid,
`ifdef POOL_ABORT_EN
   input  logic                   abort,
`endif
   output logic                   busy,
   output logic                   ctl_valid,
   output logic [address_num-1:0] adrs,
   output logic [address_num-1:0] adrs_out,
   output logic                   mux_en,
   output logic                   wr_ctrl1,
   output logic                   wr_ctrl2,
   output logic                   pool_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]             state, nxt_state;
   logic [CW-1:0]          col;
   logic [RW-1:0]          row;
   logic [address_num-1:0] out_cnt;   // index of the next output pixel
   logic                   kill;
   logic                   accept;
   logic                   last_pix;
   logic                   clr;

`ifdef POOL_ABORT_EN
   // abort only matters once a frame is in flight; in IDLE it just blocks start
   assign kill = abort;
`else
   assign kill = 1'b0;
`endif

   assign accept   = (state == RUN) && pix_valid && !kill;
   assign last_pix = (col == CW'(IMG_W-1)) && (row == RW'(IMG_H-1));
   assign clr      = kill || ((state == IDLE) && start);
   assign busy     = (state == RUN) || (state == DONE);

   always_comb begin
      nxt_state = state;
      case (state)
         IDLE:    if (start && !kill) nxt_state = RUN;
         RUN:     if (kill) nxt_state = IDLE;
                  else if (accept && last_pix) nxt_state = DONE;
         DONE:    nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= IDLE;
      else       state <= nxt_state;
   end

   // raster position and output index
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         col     <= '0;
         row     <= '0;
         out_cnt <= '0;
      end else if (clr) begin
         col     <= '0;
         row     <= '0;
         out_cnt <= '0;
      end else if (accept) begin
         if (col == CW'(IMG_W-1)) begin
            col <= '0;
            row <= (row == RW'(IMG_H-1)) ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
         if (row[0] && col[0]) out_cnt <= out_cnt + address_num'(1);
      end
   end

   // registered control; pulses drop to 0 on any cycle without an accept,
   // addresses hold so the downstream stage sees stable values in gaps
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ctl_valid <= 1'b0;
         adrs      <= '0;
         adrs_out  <= '0;
         mux_en    <= 1'b0;
         wr_ctrl1  <= 1'b0;
         wr_ctrl2  <= 1'b0;
         pool_done <= 1'b0;
      end else begin
         ctl_valid <= accept;
         mux_en    <= accept && col[0];
         wr_ctrl1  <= accept && !row[0] && col[0];
         wr_ctrl2  <= accept && row[0] && col[0];
         pool_done <= accept && last_pix;
         if (accept) begin
            adrs     <= address_num'(col >> 1);
            adrs_out <= out_cnt;
         end
      end
   end

endmodule
